// File: rtl/move_sequencer_pkg.sv
// Shared definitions for the Connect Four move sequencer: board geometry,
// move-count limits, FSM state encoding and a column-range helper.
package move_sequencer_pkg;

    localparam int NCOLS    = 7;
    localparam int NROWS    = 6;
    localparam int MAXMOVES = NCOLS * NROWS;
    localparam int COLW     = 3;
    localparam int CNTW     = 6;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_CHECK = 3'd2,
        ST_DONE  = 3'd3,
        ST_CLR   = 3'd4
    } state_t;

    // Column indices 7 (with a 3-bit select) do not exist on the board.
    function automatic logic col_legal(input logic [COLW-1:0] c);
        return c < COLW'(NCOLS);
    endfunction

endpackage

// File: rtl/move_sequencer_if.sv
// Handshake bundle between the move sequencer and the move validator.
//   vld_onoff/vld_player : column snapshot presented for checking
//   vld_go               : validator strobe
//   cur_player           : player to move
//   valid_move           : validator verdict
//   write_onoff/player   : column contents to commit when the move is valid
// master = sequencer side, slave = validator side.
interface move_sequencer_if;
    import move_sequencer_pkg::*;

    logic [NROWS-1:0] vld_onoff;
    logic [NROWS-1:0] vld_player;
    logic             vld_go;
    logic             cur_player;
    logic             valid_move;
    logic [NROWS-1:0] write_onoff;
    logic [NROWS-1:0] write_player;

    modport master (
        output vld_onoff, vld_player, vld_go, cur_player,
        input  valid_move, write_onoff, write_player
    );

    modport slave (
        input  vld_onoff, vld_player, vld_go, cur_player,
        output valid_move, write_onoff, write_player
    );

endinterface

// File: rtl/move_sequencer_board_regfile.sv
// Board storage: one word per column, {onoff, player}.
//   clk, resetn : clock, synchronous active-low reset
//   we, wcol, wdata : single synchronous write port
//   clear       : synchronous wipe of every column
//   seq_col/seq_data : combinational read for the sequencer
//   rd_col/rd_data   : combinational read for display / win check
// Out-of-range columns read as zero and are never written.
module move_sequencer_board_regfile
    import move_sequencer_pkg::*;
(
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 we,
    input  logic [COLW-1:0]      wcol,
    input  logic [2*NROWS-1:0]   wdata,
    input  logic                 clear,
    input  logic [COLW-1:0]      seq_col,
    output logic [2*NROWS-1:0]   seq_data,
    input  logic [COLW-1:0]      rd_col,
    output logic [2*NROWS-1:0]   rd_data
);

    logic [2*NROWS-1:0] mem [NCOLS];

    always_ff @(posedge clk) begin
        if (!resetn || clear) begin
            for (int i = 0; i < NCOLS; i++) begin
                mem[i] <= '0;
            end
        end else if (we && col_legal(wcol)) begin
            mem[wcol] <= wdata;
        end
    end

    assign seq_data = col_legal(seq_col) ? mem[seq_col] : '0;
    assign rd_data  = col_legal(rd_col)  ? mem[rd_col]  : '0;

endmodule

// File: rtl/move_sequencer.sv
// Board-state owner and move sequencer for Connect Four.
//   clk, resetn      : clock, synchronous active-low reset
//   go, col          : one-cycle move request and target column (IDLE only)
//   clear            : board wipe request (IDLE only, beats go)
//   vld_if           : validator handshake (master side)
//   busy, done       : not-IDLE flag, one-cycle completion pulse
//   move_ok          : result of the last move
//   move_count       : committed moves, board_full at the maximum
//   rd_col/rd_onoff/rd_player : combinational board read port
//
// state | meaning
// IDLE  | waiting for go or clear
// LOAD  | fetch selected column into the validator snapshot registers
// CHECK | validator strobed; commit on a legal move
// DONE  | done pulse, back to IDLE
// CLR   | wipe board, player and count
module move_sequencer
    import move_sequencer_pkg::*;
(
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 go,
    input  logic [COLW-1:0]      col,
    input  logic                 clear,
    move_sequencer_if.master     vld_if,
    output logic                 busy,
    output logic                 done,
    output logic                 move_ok,
    output logic [CNTW-1:0]      move_count,
    output logic                 board_full,
    input  logic [COLW-1:0]      rd_col,
    output logic [NROWS-1:0]     rd_onoff,
    output logic [NROWS-1:0]     rd_player
);

    state_t             state, state_nxt;
    logic [COLW-1:0]    col_q;
    logic [NROWS-1:0]   vld_onoff_q, vld_player_q;
    logic               cur_player_q;
    logic               legal;
    logic               commit;
    logic               clr_board;
    logic [2*NROWS-1:0] seq_word;
    logic [2*NROWS-1:0] rd_word;

    // State register
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = ST_IDLE;
        case (state)
            ST_IDLE: begin
                if (clear)   state_nxt = ST_CLR;
                else if (go) state_nxt = ST_LOAD;
                else         state_nxt = ST_IDLE;
            end
            ST_LOAD:  state_nxt = ST_CHECK;
            ST_CHECK: state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            ST_CLR:   state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // board_full gates the commit, so move_count can never pass MAXMOVES.
    assign legal = col_legal(col_q) && vld_if.valid_move && !board_full;

    // Output logic
    always_comb begin
        busy      = 1'b1;
        done      = 1'b0;
        commit    = 1'b0;
        clr_board = 1'b0;
        case (state)
            ST_IDLE:  busy      = 1'b0;
            ST_CHECK: commit    = legal;
            ST_DONE:  done      = 1'b1;
            ST_CLR:   clr_board = 1'b1;
            default:  ;
        endcase
    end

    assign vld_if.vld_go = (state == ST_CHECK);

    // Move datapath
    always_ff @(posedge clk) begin
        if (!resetn) begin
            col_q        <= '0;
            vld_onoff_q  <= '0;
            vld_player_q <= '0;
            cur_player_q <= 1'b0;
            move_count   <= '0;
            move_ok      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!clear && go) col_q <= col;
                end
                ST_LOAD: begin
                    vld_onoff_q  <= seq_word[2*NROWS-1:NROWS];
                    vld_player_q <= seq_word[NROWS-1:0];
                end
                ST_CHECK: begin
                    move_ok <= legal;
                    if (legal) begin
                        cur_player_q <= ~cur_player_q;
                        move_count   <= move_count + CNTW'(1);
                    end
                end
                ST_CLR: begin
                    cur_player_q <= 1'b0;
                    move_count   <= '0;
                    move_ok      <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign board_full        = (move_count == CNTW'(MAXMOVES));
    assign vld_if.vld_onoff  = vld_onoff_q;
    assign vld_if.vld_player = vld_player_q;
    assign vld_if.cur_player = cur_player_q;

    move_sequencer_board_regfile u_board (
        .clk      (clk),
        .resetn   (resetn),
        .we       (commit),
        .wcol     (col_q),
        .wdata    ({vld_if.write_onoff, vld_if.write_player}),
        .clear    (clr_board),
        .seq_col  (col_q),
        .seq_data (seq_word),
        .rd_col   (rd_col),
        .rd_data  (rd_word)
    );

    assign rd_onoff  = rd_word[2*NROWS-1:NROWS];
    assign rd_player = rd_word[NROWS-1:0];

endmodule

// File: tb/tb_move_sequencer.sv
module tb_move_sequencer;

    logic       clk = 1'b0;
    logic       resetn;
    logic       go;
    logic [2:0] col;
    logic       clear;
    logic       busy, done, move_ok, board_full;
    logic [5:0] move_count;
    logic [2:0] rd_col;
    logic [5:0] rd_onoff, rd_player;

    move_sequencer_if vif ();

    move_sequencer dut (
        .clk        (clk),
        .resetn     (resetn),
        .go         (go),
        .col        (col),
        .clear      (clear),
        .vld_if     (vif),
        .busy       (busy),
        .done       (done),
        .move_ok    (move_ok),
        .move_count (move_count),
        .board_full (board_full),
        .rd_col     (rd_col),
        .rd_onoff   (rd_onoff),
        .rd_player  (rd_player)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: plain board arrays plus counters.
    logic [5:0] m_on [8];
    logic [5:0] m_pl [8];
    int         m_cnt;
    logic       m_player;

    typedef struct {
        logic [2:0] col;
        logic       vm;
        logic [5:0] wo;
        logic [5:0] wp;
        logic       exp_ok;
        logic [5:0] exp_son;
        logic [5:0] exp_spl;
        int         exp_count;
        logic       exp_player;
        logic [5:0] exp_ron;
        logic [5:0] exp_rpl;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_on[i] = '0;
            m_pl[i] = '0;
        end
        m_cnt    = 0;
        m_player = 1'b0;
    endtask

    task automatic chk_rd(input logic [2:0] c, input logic [5:0] eon, input logic [5:0] epl);
        rd_col = c;
        #1;
        chk($sformatf("rd_onoff[%0d]", c), {26'd0, rd_onoff}, {26'd0, eon});
        chk($sformatf("rd_player[%0d]", c), {26'd0, rd_player}, {26'd0, epl});
    endtask

    // Starts and ends at a negedge with the DUT idle.
    task automatic do_move(input logic [2:0] c, input logic vm, input logic [5:0] wo,
                           input logic [5:0] wp, output logic ok, output logic [5:0] s_on,
                           output logic [5:0] s_pl, output int lat, output int n_vgo);
        go = 1'b1;
        col = c;
        vif.valid_move   = vm;
        vif.write_onoff  = wo;
        vif.write_player = wp;
        lat = -1; n_vgo = 0; s_on = '0; s_pl = '0; ok = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk);
            #1 go = 1'b0;
            @(negedge clk);
            if (vif.vld_go) begin
                n_vgo++;
                s_on = vif.vld_onoff;
                s_pl = vif.vld_player;
            end
            if (done) begin
                ok  = move_ok;
                lat = i;
                break;
            end
        end
        @(negedge clk);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(posedge clk);
        #1 clear = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    // Apply one move to both DUT and model and compare everything observable.
    task automatic model_move(input logic [2:0] c, input logic vm, input logic [5:0] wo,
                              input logic [5:0] wp);
        logic       ok;
        logic [5:0] s_on, s_pl;
        int         lat, nv;
        logic       legal;
        logic [5:0] e_son, e_spl;
        e_son = (c < 3'd7) ? m_on[c] : 6'd0;
        e_spl = (c < 3'd7) ? m_pl[c] : 6'd0;
        legal = (c < 3'd7) && vm && (m_cnt < 42);
        do_move(c, vm, wo, wp, ok, s_on, s_pl, lat, nv);
        if (legal) begin
            m_on[c]  = wo;
            m_pl[c]  = wp;
            m_cnt    = m_cnt + 1;
            m_player = ~m_player;
        end
        chk("rand_latency", lat, 3);
        chk("rand_ok", {31'd0, ok}, {31'd0, legal});
        chk("rand_seen_on", {26'd0, s_on}, {26'd0, e_son});
        chk("rand_seen_pl", {26'd0, s_pl}, {26'd0, e_spl});
        chk("rand_count", {26'd0, move_count}, m_cnt);
        chk("rand_player", {31'd0, vif.cur_player}, {31'd0, m_player});
        chk("rand_full", {31'd0, board_full}, {31'd0, (m_cnt == 42)});
        begin
            logic [2:0] rc;
            rc = 3'($urandom_range(0, 7));
            chk_rd(rc, (rc < 3'd7) ? m_on[rc] : 6'd0, (rc < 3'd7) ? m_pl[rc] : 6'd0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       ok;
        logic [5:0] s_on, s_pl;
        int         lat, nv, ndone, guard;

        vecs[0] = '{3'd3, 1'b1, 6'b000001, 6'b000000, 1'b1, 6'b000000, 6'b000000, 1, 1'b1, 6'b000001, 6'b000000};
        vecs[1] = '{3'd3, 1'b1, 6'b000011, 6'b000010, 1'b1, 6'b000001, 6'b000000, 2, 1'b0, 6'b000011, 6'b000010};
        vecs[2] = '{3'd3, 1'b1, 6'b000111, 6'b000010, 1'b1, 6'b000011, 6'b000010, 3, 1'b1, 6'b000111, 6'b000010};
        vecs[3] = '{3'd3, 1'b1, 6'b001111, 6'b001010, 1'b1, 6'b000111, 6'b000010, 4, 1'b0, 6'b001111, 6'b001010};
        vecs[4] = '{3'd3, 1'b1, 6'b011111, 6'b001010, 1'b1, 6'b001111, 6'b001010, 5, 1'b1, 6'b011111, 6'b001010};
        vecs[5] = '{3'd3, 1'b1, 6'b111111, 6'b101010, 1'b1, 6'b011111, 6'b001010, 6, 1'b0, 6'b111111, 6'b101010};
        vecs[6] = '{3'd3, 1'b0, 6'b000000, 6'b000000, 1'b0, 6'b111111, 6'b101010, 6, 1'b0, 6'b111111, 6'b101010};
        vecs[7] = '{3'd7, 1'b1, 6'b111111, 6'b111111, 1'b0, 6'b000000, 6'b000000, 6, 1'b0, 6'b000000, 6'b000000};

        resetn = 1'b0; go = 1'b0; col = '0; clear = 1'b0; rd_col = '0;
        vif.valid_move = 1'b0; vif.write_onoff = '0; vif.write_player = '0;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);

        // Reset state
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_done", {31'd0, done}, 0);
        chk("rst_move_ok", {31'd0, move_ok}, 0);
        chk("rst_count", {26'd0, move_count}, 0);
        chk("rst_player", {31'd0, vif.cur_player}, 0);
        chk("rst_vld_go", {31'd0, vif.vld_go}, 0);
        chk("rst_vld_onoff", {26'd0, vif.vld_onoff}, 0);
        chk("rst_full", {31'd0, board_full}, 0);
        for (int c = 0; c < 8; c++) chk_rd(3'(c), 6'd0, 6'd0);

        // Directed table: fill column 3, overflow it, illegal column 7
        for (int v = 0; v < 8; v++) begin
            do_move(vecs[v].col, vecs[v].vm, vecs[v].wo, vecs[v].wp, ok, s_on, s_pl, lat, nv);
            chk($sformatf("vec%0d_latency", v), lat, 3);
            chk($sformatf("vec%0d_vld_go_cycles", v), nv, 1);
            chk($sformatf("vec%0d_ok", v), {31'd0, ok}, {31'd0, vecs[v].exp_ok});
            chk($sformatf("vec%0d_seen_on", v), {26'd0, s_on}, {26'd0, vecs[v].exp_son});
            chk($sformatf("vec%0d_seen_pl", v), {26'd0, s_pl}, {26'd0, vecs[v].exp_spl});
            chk($sformatf("vec%0d_count", v), {26'd0, move_count}, vecs[v].exp_count);
            chk($sformatf("vec%0d_player", v), {31'd0, vif.cur_player}, {31'd0, vecs[v].exp_player});
            chk_rd(vecs[v].col, vecs[v].exp_ron, vecs[v].exp_rpl);
        end
        chk_rd(3'd3, 6'b111111, 6'b101010);

        // go held high while busy: exactly one move, column latched at acceptance
        go = 1'b1; col = 3'd0;
        vif.valid_move = 1'b1; vif.write_onoff = 6'b000001; vif.write_player = 6'b000000;
        ndone = 0;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk);
            #1;
            col = 3'd1;
            if (i == 3) go = 1'b0;
            @(negedge clk);
            if (done) ndone++;
        end
        go = 1'b0;
        chk("busy_go_done_count", ndone, 1);
        chk("busy_go_count", {26'd0, move_count}, 7);
        chk("busy_go_player", {31'd0, vif.cur_player}, 1);
        chk_rd(3'd0, 6'b000001, 6'b000000);
        chk_rd(3'd1, 6'b000000, 6'b000000);

        // clear and go together: clear wins, no done
        clear = 1'b1; go = 1'b1; col = 3'd2; vif.valid_move = 1'b1;
        ndone = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1 clear = 1'b0; go = 1'b0;
            @(negedge clk);
            if (done) ndone++;
        end
        chk("clr_done_count", ndone, 0);
        chk("clr_count", {26'd0, move_count}, 0);
        chk("clr_player", {31'd0, vif.cur_player}, 0);
        chk("clr_busy", {31'd0, busy}, 0);
        chk("clr_move_ok", {31'd0, move_ok}, 0);
        for (int c = 0; c < 8; c++) chk_rd(3'(c), 6'd0, 6'd0);

        // Reset during CHECK with a valid move pending
        do_move(3'd4, 1'b1, 6'b000001, 6'b000000, ok, s_on, s_pl, lat, nv);
        chk("pre_rst_ok", {31'd0, ok}, 1);
        go = 1'b1; col = 3'd4;
        vif.valid_move = 1'b1; vif.write_onoff = 6'b000011; vif.write_player = 6'b000010;
        @(posedge clk);
        #1 go = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_mid_in_check", {31'd0, vif.vld_go}, 1);
        resetn = 1'b0;
        @(posedge clk);
        #1 resetn = 1'b1;
        ndone = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("rst_mid_done_count", ndone, 0);
        chk("rst_mid_busy", {31'd0, busy}, 0);
        chk("rst_mid_count", {26'd0, move_count}, 0);
        chk("rst_mid_player", {31'd0, vif.cur_player}, 0);
        chk("rst_mid_vld_onoff", {26'd0, vif.vld_onoff}, 0);
        chk("rst_mid_move_ok", {31'd0, move_ok}, 0);
        for (int c = 0; c < 8; c++) chk_rd(3'(c), 6'd0, 6'd0);

        // Random moves against the model, with occasional clears
        model_reset();
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 15) == 0) begin
                do_clear();
                model_reset();
                chk("rand_clear_count", {26'd0, move_count}, 0);
            end else begin
                model_move(3'($urandom_range(0, 7)), ($urandom_range(0, 3) != 0),
                           6'($urandom), 6'($urandom));
            end
        end

        // Fill the board to 42 moves, then keep pushing
        do_clear();
        model_reset();
        guard = 0;
        while (m_cnt < 42 && guard < 400) begin
            model_move(3'($urandom_range(0, 7)), ($urandom_range(0, 5) != 0),
                       6'($urandom), 6'($urandom));
            guard++;
        end
        chk("fill_reached_full", {31'd0, board_full}, 1);
        chk("fill_count", {26'd0, move_count}, 42);
        do_move(3'd0, 1'b1, 6'b111111, 6'b111111, ok, s_on, s_pl, lat, nv);
        chk("move43_ok", {31'd0, ok}, 0);
        chk("move43_latency", lat, 3);
        chk("move43_count", {26'd0, move_count}, 42);
        chk_rd(3'd0, m_on[0], m_pl[0]);
        for (int n = 0; n < 8; n++) begin
            model_move(3'($urandom_range(0, 7)), 1'b1, 6'($urandom), 6'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
